stage_skid_receiver: RTL
========================

// Module: stage_skid_receiver
// PURPOSE
//  Receiving end of a pipeline-stage register link: accepts a word from the upstream stage on a
//  valid/ready handshake and presents it to the downstream stage.
//  Holds up to two words (main + skid slot), so a downstream stall never drops an in-flight word.
//  in_ready is registered, which breaks the combinational ready path between pipeline stages.
//  Sits between the EX/MEM-style stage registers wherever backpressure is needed.
// PARAMETERS
//  len    32   data word width in bits
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     reset, synchronous, active-high
//  flush      in   1     sync discard of all held words (branch/exception squash)
//  in_valid   in   1     upstream word present on in_data
//  in_ready   out  1     block can accept a word this cycle
//  in_data    in   len   upstream word
//  out_valid  out  1     out_data holds a valid word
//  out_ready  in   1     downstream consumes out_data this cycle
//  out_data   out  len   word at head (main slot)
//  occupancy  out  2     words held: 0, 1 or 2
// BEHAVIOUR
//  - Transfer in  = in_valid & in_ready at a rising edge. Transfer out = out_valid & out_ready.
//  - States: EMPTY (0 words), ONE (main valid), FULL (main + skid valid).
//  - rst=1 at an edge: state<=EMPTY, main<=0, skid<=0. Highest priority. While rst is high,
//    in_ready=0 combinationally. After reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  - flush=1 (rst=0): state<=EMPTY; data regs keep their values; in_valid ignored that cycle.
//  - EMPTY: in_valid -> main<=in_data, ONE. Otherwise stay.
//  - ONE: in_valid&out_ready -> main<=in_data, stay ONE. in_valid&~out_ready -> skid<=in_data, FULL.
//         ~in_valid&out_ready -> EMPTY. Neither -> hold.
//  - FULL: in_ready=0; in_valid ignored. out_ready -> main<=skid, ONE. Else hold.
//  - in_ready = ~rst & (state != FULL). out_valid = (state != EMPTY). out_data = main.
//  - Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (1 cycle).
//  - Ordering: strict FIFO. The skid word is never presented before the main word.
//  - Throughput: 1 word/cycle sustained while out_ready=1. Full bandwidth is preserved across
//    a single-cycle stall.
//  - out_data is stable while out_valid=1 and out_ready=0.
//  - occupancy: EMPTY=0, ONE=1, FULL=2. It is encoded directly from the state.
//  - A flush in the same cycle as a would-be transfer in or out: flush wins; no word is retained.
// STRUCTURE
//  - Shared package: state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
//  - Sub-module skid_slot: a len-bit register with synchronous active-high reset to 0 and
//    active-high load. Instantiate it twice (main, skid).
//  - Top level contains only the FSM and the mux selecting in_data vs skid into main.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD -> in_ready=0 during reset;
//    afterwards out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  2 Streaming: out_ready=1, send 1,2,3,4 back-to-back -> out_data 1,2,3,4 on consecutive
//    cycles, each 1 cycle after acceptance; in_ready stays 1.
//  3 Stall: hold out_ready=0, send 32'hA then 32'hB -> occupancy=2, in_ready=0; 32'hC is held
//    off. Raise out_ready -> A, then B, then C, in order; no loss or duplication.
//  4 Drain: from FULL, in_valid=0, out_ready=1 for 3 cycles -> occupancy 2->1->0; out_valid
//    drops after the second consume.
//  5 Flush: from FULL, assert flush with in_valid=1, in_data=32'h55 for 1 cycle -> next cycle
//    out_valid=0, occupancy=0, in_ready=1; 32'h55 never appears on the output.
//  6 Random: random in_valid/out_ready at 50% for 10k cycles vs a scoreboard queue -> identical
//    order; occupancy never exceeds 2; out_data stable while out_valid&~out_ready.

Source files
------------

// File: rtl/stage_skid_receiver_pkg.sv
// Shared definitions for the stage skid receiver: state encoding and default word width.
// The state value doubles as the occupancy count, so it is exported directly.
package stage_skid_receiver_pkg;

  localparam int unsigned LEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Number of words held in each state; equals the state encoding by construction.
  function automatic logic [1:0] state_occupancy(input state_t s);
    return logic'(s == ST_ONE) ? 2'd1 : ((s == ST_FULL) ? 2'd2 : 2'd0);
  endfunction

endpackage

// File: rtl/stage_skid_receiver_skid_slot.sv
// One word of storage for the skid receiver: synchronous active-high clear, active-high load.
module skid_slot
  import stage_skid_receiver_pkg::*;
#(
  parameter int unsigned len = LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [len-1:0] i_d,
  output logic [len-1:0] o_q
);

  logic [len-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/stage_skid_receiver.sv
// Two-entry skid receiver between pipeline stage registers. in_ready is derived from the
// state register (gated only by rst), so no combinational ready path crosses the stage.
//
// Handshake: a word moves upstream->here when in_valid & in_ready at a rising edge and
// here->downstream when out_valid & out_ready at a rising edge; out_data is held stable
// while out_valid & ~out_ready, and flush discards every held word regardless of handshakes.
module stage_skid_receiver
  import stage_skid_receiver_pkg::*;
#(
  parameter int unsigned len = LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [len-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [len-1:0] out_data,
  output logic [1:0]     occupancy
);

  state_t         r_state;
  logic           w_main_load;
  logic           w_skid_load;
  logic           w_main_from_skid;
  logic [len-1:0] w_main_d;
  logic [len-1:0] w_main_q;
  logic [len-1:0] w_skid_q;

  // Slot load decode; flush suppresses every load so the data registers keep their values.
  always_comb begin
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_main_load = in_valid;
        ST_ONE: begin
          w_main_load = in_valid & out_ready;
          w_skid_load = in_valid & ~out_ready;
        end
        ST_FULL: begin
          w_main_load      = out_ready;
          w_main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (in_valid) r_state <= ST_ONE;
        ST_ONE: begin
          if (in_valid && !out_ready)      r_state <= ST_FULL;
          else if (!in_valid && out_ready) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (out_ready) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  skid_slot #(.len(len)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  skid_slot #(.len(len)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_d    (in_data),
    .o_q    (w_skid_q)
  );

  assign in_ready  = ~rst & (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = w_main_q;
  // occupancy is the FSM state itself and serves as its observation point
  assign occupancy = state_occupancy(r_state);

endmodule
